// File: rtl/ahb_cfg_default_subordinate.sv
// AHB-Lite default subordinate for unmapped address space.
// MODE 0 answers every accepted transfer with the two-cycle ERROR response.
// MODE 1 answers read-as-zero / write-ignored with OKAY.
// Both modes can insert WAIT_STATES cycles before the response.
// Errored transfers are counted, saturating, and the address and direction of
// the most recent one are kept for a debug sideband.
//
// Handshake: a transfer is accepted on a rising edge when HSEL, HREADY and
// HTRANS[1] are all high. HTRANS[1] marks NONSEQ/SEQ. Acceptance only happens
// while this block drives HREADYOUT=1, which is in IDLE and ERR2. A data phase
// completes on the first edge where HREADYOUT=1, and HRESP is valid in that
// cycle.
module ahb_cfg_default_subordinate #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 0,
   parameter int MODE        = 0,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic [1:0]            HRESP,
   output logic                  HREADYOUT,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [ADDR_WIDTH-1:0] err_addr,
   output logic                  err_write,
   output logic [1:0]            o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_t;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;
   localparam bit         IS_ERR_MODE = (MODE == 0);
   localparam bit         NO_WAIT     = (WAIT_STATES == 0);
   // The counter holds the number of WAIT cycles still to come after the current one.
   localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

   state_t                r_state;
   logic [3:0]            r_wait_cnt;
   logic                  r_hreadyout;
   logic [1:0]            r_hresp;
   logic [ADDR_WIDTH-1:0] r_cap_addr;
   logic                  r_cap_write;
   logic [CNT_WIDTH-1:0]  r_err_count;
   logic [ADDR_WIDTH-1:0] r_err_addr;
   logic                  r_err_write;

   logic                  w_accept;
   logic                  w_err_entry;
   logic [ADDR_WIDTH-1:0] w_err_addr;
   logic                  w_err_write;
   logic [CNT_WIDTH-1:0]  w_cnt_base;
   logic [CNT_WIDTH-1:0]  w_cnt_next;
   logic                  w_unused;

   // Transfer size, burst type and write data do not affect the response.
   assign w_unused = ^{HSIZE, HBURST, HWDATA, HTRANS[0]};

   assign w_accept = HSEL & HREADY & HTRANS[1];

   // Detect the edge that enters ERR1 and pick the address-phase values to log.
   // A zero-wait error uses the live address phase, because it is captured on this same edge.
   always_comb begin
      w_err_entry = 1'b0;
      w_err_addr  = r_cap_addr;
      w_err_write = r_cap_write;
      case (r_state)
         ST_IDLE, ST_ERR2: begin
            if (w_accept && NO_WAIT && IS_ERR_MODE) begin
               w_err_entry = 1'b1;
               w_err_addr  = HADDR;
               w_err_write = HWRITE;
            end
         end
         ST_WAIT: begin
            if ((r_wait_cnt == 4'd0) && IS_ERR_MODE) begin
               w_err_entry = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Saturating increment. A simultaneous clear takes effect first, so the count restarts at 1.
   always_comb begin
      w_cnt_base = clr_err ? '0 : r_err_count;
      w_cnt_next = (&w_cnt_base) ? w_cnt_base : (w_cnt_base + CNT_WIDTH'(1));
   end

   // Response FSM. HREADYOUT and HRESP are registered alongside the next state.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state     <= ST_IDLE;
         r_wait_cnt  <= 4'd0;
         r_hreadyout <= 1'b1;
         r_hresp     <= RESP_OKAY;
         r_cap_addr  <= '0;
         r_cap_write <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_ERR2: begin
               if (w_accept) begin
                  r_cap_addr  <= HADDR;
                  r_cap_write <= HWRITE;
                  if (!NO_WAIT) begin
                     r_state     <= ST_WAIT;
                     r_wait_cnt  <= WS_LOAD;
                     r_hreadyout <= 1'b0;
                     r_hresp     <= RESP_OKAY;
                  end else if (IS_ERR_MODE) begin
                     r_state     <= ST_ERR1;
                     r_hreadyout <= 1'b0;
                     r_hresp     <= RESP_ERROR;
                  end else begin
                     r_state     <= ST_IDLE;
                     r_hreadyout <= 1'b1;
                     r_hresp     <= RESP_OKAY;
                  end
               end else begin
                  r_state     <= ST_IDLE;
                  r_hreadyout <= 1'b1;
                  r_hresp     <= RESP_OKAY;
               end
            end
            ST_WAIT: begin
               if (r_wait_cnt == 4'd0) begin
                  if (IS_ERR_MODE) begin
                     r_state     <= ST_ERR1;
                     r_hreadyout <= 1'b0;
                     r_hresp     <= RESP_ERROR;
                  end else begin
                     r_state     <= ST_IDLE;
                     r_hreadyout <= 1'b1;
                     r_hresp     <= RESP_OKAY;
                  end
               end else begin
                  r_wait_cnt <= r_wait_cnt - 4'd1;
               end
            end
            ST_ERR1: begin
               r_state     <= ST_ERR2;
               r_hreadyout <= 1'b1;
               r_hresp     <= RESP_ERROR;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_hreadyout <= 1'b1;
               r_hresp     <= RESP_OKAY;
            end
         endcase
      end
   end

   // Error capture. It updates on entry to ERR1; otherwise clr_err wipes the log.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_err_count <= '0;
         r_err_addr  <= '0;
         r_err_write <= 1'b0;
      end else if (w_err_entry) begin
         r_err_count <= w_cnt_next;
         r_err_addr  <= w_err_addr;
         r_err_write <= w_err_write;
      end else if (clr_err) begin
         r_err_count <= '0;
         r_err_addr  <= '0;
         r_err_write <= 1'b0;
      end
   end

   assign HRDATA      = '0;
   assign HRESP       = r_hresp;
   assign HREADYOUT   = r_hreadyout;
   assign err_count   = r_err_count;
   assign err_addr    = r_err_addr;
   assign err_write   = r_err_write;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb_cfg_default_subordinate.sv
// Bench for ahb_cfg_default_subordinate.
// Six configurations share one address-phase stimulus stream.
// Each instance sees HREADY gated by its own expected HREADYOUT, as a system mux would.
// A per-instance phase-index model predicts the outputs and is compared on every negedge.
// Directed literal checks pin the model at the key points.
module tb_ahb_cfg_default_subordinate;

   localparam int NI = 6;

   function automatic int cfg_mode(input int g);
      case (g)
         2, 5:    return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int cfg_ws(input int g);
      case (g)
         1:       return 3;
         4, 5:    return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int cfg_cw(input int g);
      return (g == 3) ? 2 : 16;
   endfunction

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // shared stimulus
   logic        hsel, hwrite, clr, hready_gate;
   logic [1:0]  htrans;
   logic [31:0] haddr, hwdata;
   logic [2:0]  hsize, hburst;

   // DUT outputs and model expectations, one element per instance
   wire        d_rdy   [NI];
   wire [1:0]  d_resp  [NI];
   wire [31:0] d_rdata [NI];
   wire [15:0] d_cnt   [NI];
   wire [31:0] d_addr  [NI];
   wire        d_wr    [NI];
   wire        x_rdy   [NI];
   wire [1:0]  x_resp  [NI];
   wire [15:0] x_cnt   [NI];
   wire [31:0] x_addr  [NI];
   wire        x_wr    [NI];

   int n_checks = 0;
   int n_fail   = 0;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int M  = cfg_mode(g);
      localparam int W  = cfg_ws(g);
      localparam int CW = cfg_cw(g);
      localparam int N  = W + ((M == 0) ? 2 : 1);
      localparam logic [15:0] CMAX = 16'((32'd1 << CW) - 32'd1);

      logic [CW-1:0] w_cnt;
      logic [1:0]    w_dbg;
      logic          w_hready;

      // Model state: m_k is the data-phase cycle index (0 = no transfer in flight).
      int          m_k;
      logic [15:0] m_cnt, m_base, m_cnt_nx;
      logic [31:0] m_addr, m_cap, m_ea;
      logic        m_wr, m_cap_wr, m_ew;
      logic        m_rdy, m_acc, m_err;
      logic [1:0]  m_resp;

      assign w_hready = hready_gate & m_rdy;

      ahb_cfg_default_subordinate #(
         .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(W), .MODE(M), .CNT_WIDTH(CW)
      ) u_dut (
         .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
         .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
         .HREADY(w_hready), .clr_err(clr), .HRDATA(d_rdata[g]), .HRESP(d_resp[g]),
         .HREADYOUT(d_rdy[g]), .err_count(w_cnt), .err_addr(d_addr[g]),
         .err_write(d_wr[g]), .o_dbg_state(w_dbg)
      );
      assign d_cnt[g] = 16'(w_cnt);

      // Expected outputs for data-phase cycle k:
      // cycles 1..W wait with OKAY, then ERROR,ERROR (MODE 0) or a ready OKAY (MODE 1).
      always_comb begin
         m_rdy  = 1'b1;
         m_resp = 2'b00;
         if (m_k != 0) begin
            if (m_k <= W) begin
               m_rdy = 1'b0;
            end else if (M == 0) begin
               m_resp = 2'b01;
               m_rdy  = (m_k == W + 2);
            end
         end
         m_acc = hsel & hready_gate & htrans[1] & m_rdy;
         m_err = 1'b0;
         m_ea  = m_cap;
         m_ew  = m_cap_wr;
         if (M == 0) begin
            if (m_acc && (W == 0)) begin
               m_err = 1'b1;
               m_ea  = haddr;
               m_ew  = hwrite;
            end else if (!m_acc && (m_k != 0) && (m_k == W)) begin
               m_err = 1'b1;
            end
         end
         m_base   = clr ? 16'd0 : m_cnt;
         m_cnt_nx = (m_base == CMAX) ? m_base : m_base + 16'd1;
      end

      always @(posedge clk or posedge rst) begin
         if (rst) begin
            m_k      <= 0;
            m_cnt    <= 16'd0;
            m_addr   <= 32'd0;
            m_wr     <= 1'b0;
            m_cap    <= 32'd0;
            m_cap_wr <= 1'b0;
         end else begin
            m_k <= m_acc ? 1 : (((m_k == 0) || (m_k == N)) ? 0 : m_k + 1);
            if (m_acc) begin
               m_cap    <= haddr;
               m_cap_wr <= hwrite;
            end
            if (m_err) begin
               m_cnt  <= m_cnt_nx;
               m_addr <= m_ea;
               m_wr   <= m_ew;
            end else if (clr) begin
               m_cnt  <= 16'd0;
               m_addr <= 32'd0;
               m_wr   <= 1'b0;
            end
         end
      end

      assign x_rdy[g]  = m_rdy;
      assign x_resp[g] = m_resp;
      assign x_cnt[g]  = m_cnt;
      assign x_addr[g] = m_addr;
      assign x_wr[g]   = m_wr;
   end

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d actual=%h expected=%h t=%0t", nm, g, act, exp, $time);
      end
   endtask

   // compare process: model vs DUT every cycle, away from the active edge
   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         chk("hreadyout", g, 32'(d_rdy[g]), 32'(x_rdy[g]));
         chk("hresp", g, 32'(d_resp[g]), 32'(x_resp[g]));
         chk("hrdata", g, d_rdata[g], 32'h0);
         chk("err_count", g, 32'(d_cnt[g]), 32'(x_cnt[g]));
         chk("err_addr", g, d_addr[g], x_addr[g]);
         chk("err_write", g, 32'(d_wr[g]), 32'(x_wr[g]));
      end
   end

   // driver tasks
   task automatic drive(input logic [1:0] trans, input logic [31:0] addr, input logic wr);
      hsel   = 1'b1;
      htrans = trans;
      haddr  = addr;
      hwrite = wr;
      hwdata = $urandom;
   endtask

   task automatic idle_bus();
      hsel   = 1'b0;
      htrans = 2'b00;
      haddr  = 32'(16'($urandom_range(0, 65535)));
      hwrite = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [4:0] t2_rdy;
   logic [4:0] t2_err;
   logic [1:0] t4_trans [6];
   logic       t4_gate  [6];

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      hready_gate = 1'b1;
      hsize = 3'b010;
      hburst = 3'b000;
      hwdata = 32'h0;
      idle_bus();
      t2_rdy = 5'b10000;
      t2_err = 5'b11000;
      t4_trans = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
      t4_gate  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      // reset values
      cycles(2);
      chk("rst_hreadyout", 0, 32'(d_rdy[0]), 32'h1);
      chk("rst_hresp", 0, 32'(d_resp[0]), 32'h0);
      chk("rst_err_count", 0, 32'(d_cnt[0]), 32'h0);
      chk("rst_err_addr", 0, d_addr[0], 32'h0);
      rst = 1'b0;
      cycles(2);

      // 1: MODE0 WS0 read error
      drive(2'b10, 32'h4000_0000, 1'b0);
      cycles(1);
      idle_bus();
      @(negedge clk);
      chk("t1_err1_rdy", 0, 32'(d_rdy[0]), 32'h0);
      chk("t1_err1_resp", 0, 32'(d_resp[0]), 32'h1);
      @(negedge clk);
      chk("t1_err2_rdy", 0, 32'(d_rdy[0]), 32'h1);
      chk("t1_err2_resp", 0, 32'(d_resp[0]), 32'h1);
      chk("t1_err_count", 0, 32'(d_cnt[0]), 32'h1);
      chk("t1_err_addr", 0, d_addr[0], 32'h4000_0000);
      chk("t1_err_write", 0, 32'(d_wr[0]), 32'h0);
      cycles(10);

      // 2: MODE0 WS3 write error
      drive(2'b10, 32'h0000_0010, 1'b1);
      cycles(1);
      idle_bus();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_rdy", 1, 32'(d_rdy[1]), 32'(t2_rdy[i]));
         chk("t2_resp", 1, 32'(d_resp[1]), 32'(t2_err[i]));
      end
      chk("t2_err_write", 1, 32'(d_wr[1]), 32'h1);
      chk("t2_err_addr", 1, d_addr[1], 32'h0000_0010);
      cycles(8);

      // 3: MODE1 WS0, four back-to-back SEQ reads
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 32'h0000_0100 + 32'(i * 4), 1'b0);
         @(negedge clk);
         chk("t3_rdy", 2, 32'(d_rdy[2]), 32'h1);
         chk("t3_resp", 2, 32'(d_resp[2]), 32'h0);
         chk("t3_rdata", 2, d_rdata[2], 32'h0);
         cycles(1);
      end
      idle_bus();
      @(negedge clk);
      chk("t3_rdy_last", 2, 32'(d_rdy[2]), 32'h1);
      chk("t3_err_count", 2, 32'(d_cnt[2]), 32'h0);
      cycles(8);

      // 4: IDLE/BUSY selected, NONSEQ with HREADY low: never accepted
      for (int i = 0; i < 6; i++) begin
         drive(t4_trans[i], 32'h0000_0200, 1'b1);
         hready_gate = t4_gate[i];
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            chk("t4_rdy", g, 32'(d_rdy[g]), 32'h1);
            chk("t4_resp", g, 32'(d_resp[g]), 32'h0);
         end
         cycles(1);
      end
      idle_bus();
      hready_gate = 1'b1;
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         chk("t4_rdy_after", g, 32'(d_rdy[g]), 32'h1);
      end
      cycles(2);

      // 5: saturation at CNT_WIDTH=2, then a clear coinciding with an ERR1 entry
      for (int i = 0; i < 5; i++) begin
         drive(2'b10, 32'h2000_0000 + 32'(i * 4), 1'b0);
         cycles(1);
         idle_bus();
         cycles(6);
      end
      chk("t5_saturated", 3, 32'(d_cnt[3]), 32'h3);
      chk("t5_addr", 3, d_addr[3], 32'h2000_0010);
      drive(2'b10, 32'h5000_0000, 1'b1);
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      idle_bus();
      @(negedge clk);
      chk("t5_clr_count", 3, 32'(d_cnt[3]), 32'h1);
      chk("t5_clr_count", 0, 32'(d_cnt[0]), 32'h1);
      chk("t5_clr_addr", 3, d_addr[3], 32'h5000_0000);
      chk("t5_clr_write", 3, 32'(d_wr[3]), 32'h1);
      cycles(8);

      // 6: reset asserted while in ERR1 (MODE0, WS2)
      drive(2'b10, 32'h6000_0000, 1'b1);
      cycles(1);
      idle_bus();
      cycles(2);
      chk("t6_in_err1_rdy", 4, 32'(d_rdy[4]), 32'h0);
      chk("t6_in_err1_resp", 4, 32'(d_resp[4]), 32'h1);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_rst_rdy", 4, 32'(d_rdy[4]), 32'h1);
      chk("t6_rst_resp", 4, 32'(d_resp[4]), 32'h0);
      chk("t6_rst_count", 4, 32'(d_cnt[4]), 32'h0);
      chk("t6_rst_addr", 4, d_addr[4], 32'h0);
      cycles(1);
      rst = 1'b0;
      cycles(2);
      drive(2'b10, 32'h7000_0004, 1'b0);
      cycles(1);
      idle_bus();
      cycles(5);
      chk("t6_after_count", 4, 32'(d_cnt[4]), 32'h1);
      chk("t6_after_addr", 4, d_addr[4], 32'h7000_0004);
      chk("t6_after_write", 4, 32'(d_wr[4]), 32'h0);
      cycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
